// File: rtl/viterbi_pkg.sv
// Shared constants for the hard-decision Viterbi path-metric unit.
package viterbi_pkg;
  localparam int BM_W        = 2;
  localparam int PM_W_DEF    = 8;
  localparam int INIT_HI_DEF = 64;
  localparam int NORM_SUB    = 1 << (PM_W_DEF - 1);

  // Survivor decision encoding: which predecessor won.
  localparam logic DEC_UPPER = 1'b0;
  localparam logic DEC_LOWER = 1'b1;
endpackage

// File: rtl/acs_node.sv
// One successor of the ACS butterfly: add, compare, select, normalise, saturate.
// The add stage is exposed separately so the top can optionally register it.
module acs_node
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W:0]   sum_a,
  output logic [PM_W:0]   sum_b,
  input  logic [PM_W:0]   cmp_a,
  input  logic [PM_W:0]   cmp_b,
  input  logic            norm,
  output logic [PM_W-1:0] nxt,
  output logic            dec
);
  localparam logic [PM_W:0] NSUB = (PM_W+1)'(1) << (PM_W - 1);

  logic [PM_W:0] sel;
  logic [PM_W:0] red;

  assign sum_a = {1'b0, pm0} + {{(PM_W+1-BM_W){1'b0}}, bm0};
  assign sum_b = {1'b0, pm1} + {{(PM_W+1-BM_W){1'b0}}, bm1};

  always_comb begin
    sel = cmp_a;
    dec = DEC_UPPER;
    // Strict less-than: ties keep the upper predecessor.
    if (cmp_b < cmp_a) begin
      sel = cmp_b;
      dec = DEC_LOWER;
    end
    red = norm ? (sel - NSUB) : sel;
    nxt = red[PM_W] ? '1 : red[PM_W-1:0];
  end
endmodule

// File: rtl/acs_butterfly.sv
// Radix-2 ACS butterfly: successors j and j+N/2 from predecessors 2j, 2j+1.
// Define ACS_PIPE_EN to register the adder outputs (latency 2 instead of 1).
module acs_butterfly
  import viterbi_pkg::*;
#(
  parameter int PM_W      = PM_W_DEF,
  parameter int INIT_HI   = INIT_HI_DEF,
  parameter bit IS_STATE0 = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            in_valid,
  input  logic [PM_W-1:0] pm_in0,
  input  logic [PM_W-1:0] pm_in1,
  input  logic [BM_W-1:0] bm00,
  input  logic [BM_W-1:0] bm01,
  input  logic [BM_W-1:0] bm10,
  input  logic [BM_W-1:0] bm11,
  input  logic            norm_req,
  output logic [PM_W-1:0] pm_out0,
  output logic [PM_W-1:0] pm_out1,
  output logic            dec0,
  output logic            dec1,
  output logic            out_valid,
  output logic            msb_hit
);
  localparam logic [PM_W-1:0] INIT1 = PM_W'(INIT_HI);
  localparam logic [PM_W-1:0] INIT0 = IS_STATE0 ? '0 : INIT1;

  logic [1:0][BM_W-1:0] bm_up, bm_lo;
  logic [1:0][PM_W:0]   sum_a, sum_b, cmp_a, cmp_b;
  logic [1:0][PM_W-1:0] nxt, pm_q;
  logic [1:0]           dec_n, dec_q;
  logic                 cmp_norm, step_vld;

  assign bm_up = {bm01, bm00};
  assign bm_lo = {bm11, bm10};

  for (genvar k = 0; k < 2; k++) begin : g_node
    acs_node #(.PM_W(PM_W)) u_node (
      .pm0(pm_in0), .pm1(pm_in1), .bm0(bm_up[k]), .bm1(bm_lo[k]),
      .sum_a(sum_a[k]), .sum_b(sum_b[k]),
      .cmp_a(cmp_a[k]), .cmp_b(cmp_b[k]), .norm(cmp_norm),
      .nxt(nxt[k]), .dec(dec_n[k])
    );
  end

`ifdef ACS_PIPE_EN
  logic vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= 1'b0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      cmp_norm <= 1'b0;
    end else if (frame_start) begin
      vld_pipe <= 1'b0;  // drop the in-flight step on a new frame
    end else begin
      vld_pipe <= in_valid;
      if (in_valid) begin
        cmp_a    <= sum_a;
        cmp_b    <= sum_b;
        cmp_norm <= norm_req;
      end
    end
  end

  assign step_vld = vld_pipe;
`else
  assign cmp_a    = sum_a;
  assign cmp_b    = sum_b;
  assign cmp_norm = norm_req;
  assign step_vld = in_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q      <= {INIT1, INIT0};
      dec_q     <= '0;
      out_valid <= 1'b0;
    end else if (frame_start) begin
      pm_q      <= {INIT1, INIT0};
      dec_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= step_vld;
      if (step_vld) begin
        pm_q  <= nxt;
        dec_q <= dec_n;
      end
    end
  end

  assign pm_out0 = pm_q[0];
  assign pm_out1 = pm_q[1];
  assign dec0    = dec_q[0];
  assign dec1    = dec_q[1];
  assign msb_hit = pm_q[0][PM_W-1] | pm_q[1][PM_W-1];
endmodule

// File: tb/tb_acs_butterfly.sv
// Scoreboard bench for acs_butterfly (state-0 instance, PM_W=8, INIT_HI=64).
module tb_acs_butterfly;
`ifdef ACS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] p0, p1;
    logic       d0, d1, m;
    int         due;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, frame_start = 1'b0, in_valid = 1'b0, norm_req = 1'b0;
  logic [7:0] pm_in0 = '0, pm_in1 = '0, pm_out0, pm_out1;
  logic [1:0] bm00 = '0, bm01 = '0, bm10 = '0, bm11 = '0;
  logic       dec0, dec1, out_valid, msb_hit;

  int   cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];

  acs_butterfly #(.PM_W(8), .INIT_HI(64), .IS_STATE0(1'b1)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .pm_in0(pm_in0), .pm_in1(pm_in1), .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
    .norm_req(norm_req), .pm_out0(pm_out0), .pm_out1(pm_out1), .dec0(dec0), .dec1(dec1),
    .out_valid(out_valid), .msb_hit(msb_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ACS_PIPE_EN
  logic iv_d = 1'b0;
  always @(posedge clk) begin
    if (!rst) assert (!(in_valid && iv_d)) else $error("back-to-back in_valid with ACS_PIPE_EN");
    iv_d <= in_valid;
  end
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("pm_out0", pm_out0, e.p0);
        chk("pm_out1", pm_out1, e.p1);
        chk("dec0", dec0, e.d0);
        chk("dec1", dec1, e.d1);
        chk("msb_hit", msb_hit, e.m);
      end
    end
  end

  task automatic issue(input logic [7:0] p0, input logic [7:0] p1,
                       input logic [1:0] b00, input logic [1:0] b01,
                       input logic [1:0] b10, input logic [1:0] b11, input logic nrm,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic ed0, input logic ed1, input logic em);
    exp_t e;
    @(posedge clk); #1;
    pm_in0 = p0; pm_in1 = p1; bm00 = b00; bm01 = b01; bm10 = b10; bm11 = b11;
    norm_req = nrm; in_valid = 1'b1;
    e.p0 = e0; e.p1 = e1; e.d0 = ed0; e.d1 = ed1; e.m = em; e.due = cyc + LAT;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; norm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pm_out0", pm_out0, 0);
    chk("rst_pm_out1", pm_out1, 64);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_msb_hit", msb_hit, 0);
    chk("rst_dec", {dec1, dec0}, 0);

    //     pm0  pm1  b00 b01 b10 b11 nrm   e0   e1  d0 d1 msb
    issue( 20,   5,  1,  0,  1,  2,  0,    6,   7,  1, 1, 0);  // selection
    issue( 10,  12,  2,  0,  0,  0,  0,   12,  10,  0, 0, 0);  // tie -> upper
    issue(200, 190,  0,  1,  2,  1,  1,   64,  63,  1, 1, 0);  // normalise
    issue(  3,   3,  0,  3,  1,  0,  0,    3,   3,  0, 1, 0);
    issue(130, 140,  0,  3,  0,  0,  0,  130, 133,  0, 0, 1);
    issue(255, 254,  2,  2,  2,  2,  0,  255, 255,  1, 1, 1);  // saturate
    drain();

    // frame_start wins over a simultaneous in_valid
    @(posedge clk); #1;
    frame_start = 1'b1; in_valid = 1'b1; pm_in0 = 8'd1; pm_in1 = 8'd1;
    @(posedge clk); #1;
    frame_start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fs_pm_out0", pm_out0, 0);
    chk("fs_pm_out1", pm_out1, 64);
    chk("fs_out_valid", out_valid, 0);
    chk("fs_msb_hit", msb_hit, 0);
    chk("fs_dec", {dec1, dec0}, 0);
    drain();

    // Asynchronous reset between clock edges
    issue( 20,   5,  1,  0,  1,  2,  0,    6,   7,  1, 1, 0);
    drain();
    chk("pre_arst_pm_out0", pm_out0, 6);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_pm_out0", pm_out0, 0);
    chk("arst_pm_out1", pm_out1, 64);
    chk("arst_dec", {dec1, dec0}, 0);
    chk("arst_out_valid", out_valid, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
